multiway_light_controller: RTL
==============================

MULTIWAY_LIGHT_CONTROLLER -- requirements
Module: multiway_light_controller

Interface
REQ-001 SHALL have parameter N_WAY, default 4: number of approaches, legal range 2..8.
REQ-002 SHALL have parameter GREEN_MIN, default 4: minimum green duration in cycles, at least 1.
REQ-003 SHALL have parameter GREEN_MAX, default 8: maximum green duration under competing demand, at least GREEN_MIN.
REQ-004 SHALL have parameter YELLOW_T, default 2: yellow duration in cycles, at least 1.
REQ-005 SHALL have parameter ALLRED_T, default 1: all-red clearance duration in cycles, at least 1.
REQ-006 SHALL have port CLK, input, 1 bit: single clock, rising edge.
REQ-007 SHALL have port RES, input, 1 bit: reset, asynchronous, active-low.
REQ-008 SHALL have port REQ, input, N_WAY bits: per-approach vehicle-present sensor, level.
REQ-009 SHALL have port RED, output, N_WAY bits: red lamp per approach.
REQ-010 SHALL have port YEL, output, N_WAY bits: yellow lamp per approach.
REQ-011 SHALL have port GRN, output, N_WAY bits: green lamp per approach.
REQ-012 SHALL have port PHASE, output, clog2(N_WAY) bits: index of the approach currently served.
REQ-013 SHALL have port STATE, output, 2 bits: 00 ALLRED, 01 GREEN, 10 YELLOW; 11 never driven.

Function
REQ-014 SHALL implement a three-state FSM ALLRED -> GREEN -> YELLOW -> ALLRED, with a dwell timer that is zeroed on every state entry.
REQ-015 SHALL make every state entry last at least one full cycle; ALLRED SHALL last exactly ALLRED_T cycles and YELLOW exactly YELLOW_T cycles.
REQ-016 SHALL hold a pending register pend[N_WAY]: REQ[i] high at an edge sets pend[i]; pend[PHASE] is cleared and held clear while in GREEN.
REQ-017 SHALL base all FSM decisions on registered pend, giving one cycle of latency from REQ to decision.
REQ-018 SHALL define "competing" as any pend[j] set with j not equal to PHASE.
REQ-019 SHALL leave GREEN on the edge where timer = GREEN_MIN-1, competing is true and REQ[PHASE] = 0 (gap-out), or where timer >= GREEN_MIN-1, competing is true and REQ[PHASE] falls (gap-out after extension).
REQ-020 SHALL leave GREEN on the edge where timer = GREEN_MAX-1 and competing is true (max-out), regardless of REQ[PHASE].
REQ-021 SHALL rest on GREEN indefinitely when competing is false, saturating the timer at GREEN_MAX-1.
REQ-022 SHALL, on leaving ALLRED, set PHASE to the first pending index in round-robin order starting at PHASE+1 mod N_WAY; if none is pending, PHASE+1 mod N_WAY.
REQ-023 SHALL decode outputs from registers only: GRN[PHASE]=1 in GREEN, YEL[PHASE]=1 in YELLOW, and RED=1 for all other bits.
REQ-024 SHALL guarantee that at most one GRN or YEL bit is high at any time and that exactly one lamp per approach is lit.
REQ-025 SHALL give priority to clearing pend[PHASE] during GREEN over a simultaneous REQ[PHASE] set.

Reset
REQ-026 SHALL, while RES=0, force STATE=00, PHASE=N_WAY-1, timer=0, pend=0, RED=all ones, YEL=0 and GRN=0, asynchronously and from any state.
REQ-027 SHALL, after RES rises, run one full ALLRED_T interval before the first GREEN, serving approach 0 when nothing is pending.

Structure
REQ-028 SHALL place the STATE encoding constants and the timer width function in the shared package light_ctrl_pkg.
REQ-029 SHALL implement round-robin next-phase selection as the sub-module rr_next_sel (inputs pend and PHASE; output next index), combinational and parametrised by N_WAY.

Verification (N_WAY=4, GREEN_MIN=4, GREEN_MAX=8, YELLOW_T=2, ALLRED_T=1)
REQ-030 SHALL verify: RES low 10 cycles, REQ=0 -> RED=1111 and STATE=00 during reset; one cycle after release GRN=0001 and PHASE=0, holding for 50 cycles.
REQ-031 SHALL verify: way 0 green, REQ=0100 pulsed for 1 cycle -> green lasts 4 cycles from entry, YEL=0001 for 2 cycles, all red for 1 cycle, then GRN=0100.
REQ-032 SHALL verify: way 0 green, REQ[0] held high, REQ=0010 pulsed -> GRN=0001 lasts exactly 8 cycles (max-out), then the yellow and all-red sequence, then GRN=0010.
REQ-033 SHALL verify: way 0 green, pend 1010 set -> service order way 1 then way 3, with PHASE sequence 0,1,3.
REQ-034 SHALL verify: RES pulsed low during YELLOW -> RED=1111 immediately (asynchronously), pend=0, and restart per REQ-027.
REQ-035 SHALL check by assertion every cycle: one-hot-or-zero on GRN|YEL, and RED = ~(GRN|YEL).

Source files
------------

// File: rtl/light_ctrl_pkg.sv
// Shared definitions for the multiway traffic light controller:
// FSM state encoding and the dwell-timer width helper.
package light_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_ALLRED = 2'b00,
        ST_GREEN  = 2'b01,
        ST_YELLOW = 2'b10
    } light_state_t;

    // Timer must hold 0..(longest dwell - 1); never narrower than one bit.
    function automatic int timer_width(input int green_max, input int yellow_t, input int allred_t);
        int longest;
        longest = green_max;
        if (yellow_t > longest) longest = yellow_t;
        if (allred_t > longest) longest = allred_t;
        return (longest <= 2) ? 1 : $clog2(longest);
    endfunction

endpackage

// File: rtl/rr_next_sel.sv
// Round-robin next-approach selector: first pending index after the
// current phase, falling back to phase+1 when nothing is pending.
module rr_next_sel #(
    parameter int N_WAY = 4
) (
    input  logic [N_WAY-1:0]         pend,
    input  logic [$clog2(N_WAY)-1:0] phase,
    output logic [$clog2(N_WAY)-1:0] next_phase
);

    localparam int PW = $clog2(N_WAY);

    logic [PW-1:0]    cand [N_WAY];
    logic [N_WAY-1:0] hit;

    // cand[gi] is the approach gi+1 steps ahead of the current phase.
    generate
        for (genvar gi = 0; gi < N_WAY; gi++) begin : g_cand
            logic [PW:0] sum;
            logic [PW:0] wrapped;
            assign sum      = {1'b0, phase} + (PW+1)'(gi + 1);
            assign wrapped  = sum - (PW+1)'(N_WAY);
            assign cand[gi] = (sum >= (PW+1)'(N_WAY)) ? wrapped[PW-1:0] : sum[PW-1:0];
            assign hit[gi]  = pend[cand[gi]];
        end
    endgenerate

    always_comb begin
        next_phase = cand[0];
        for (int k = N_WAY - 1; k >= 0; k--) begin
            if (hit[k]) next_phase = cand[k];
        end
    end

endmodule

// File: rtl/multiway_light_controller.sv
// Multi-approach traffic light controller: ALLRED -> GREEN -> YELLOW cycle
// with gap-out / max-out green termination and round-robin service order.
module multiway_light_controller
    import light_ctrl_pkg::*;
#(
    parameter int N_WAY     = 4,
    parameter int GREEN_MIN = 4,
    parameter int GREEN_MAX = 8,
    parameter int YELLOW_T  = 2,
    parameter int ALLRED_T  = 1
) (
    input  logic                     CLK,
    input  logic                     RES,
    input  logic [N_WAY-1:0]         REQ,
    output logic [N_WAY-1:0]         RED,
    output logic [N_WAY-1:0]         YEL,
    output logic [N_WAY-1:0]         GRN,
    output logic [$clog2(N_WAY)-1:0] PHASE,
    output logic [1:0]               STATE
);

    localparam int PW = $clog2(N_WAY);
    localparam int TW = timer_width(GREEN_MAX, YELLOW_T, ALLRED_T);

    light_state_t     state_reg, state_next;
    logic [PW-1:0]    phase_reg, phase_next;
    logic [TW-1:0]    timer_reg, timer_next;
    logic [N_WAY-1:0] pend_reg, pend_next;
    logic [N_WAY-1:0] req_prev_reg;
    logic [N_WAY-1:0] phase_onehot;
    logic [PW-1:0]    rr_phase;
    logic             competing;
    logic             gap_out, gap_out_ext, max_out;

    generate
        for (genvar gi = 0; gi < N_WAY; gi++) begin : g_onehot
            assign phase_onehot[gi] = (phase_reg == PW'(gi));
        end
    endgenerate

    rr_next_sel #(.N_WAY(N_WAY)) u_rr (
        .pend       (pend_reg),
        .phase      (phase_reg),
        .next_phase (rr_phase)
    );

    assign competing   = |(pend_reg & ~phase_onehot);
    assign gap_out     = competing && !REQ[phase_reg] && (timer_reg == TW'(GREEN_MIN - 1));
    // Extension ends when the served approach's sensor drops after minimum green.
    assign gap_out_ext = competing && (timer_reg >= TW'(GREEN_MIN - 1))
                         && req_prev_reg[phase_reg] && !REQ[phase_reg];
    assign max_out     = competing && (timer_reg == TW'(GREEN_MAX - 1));

    always_comb begin
        state_next = state_reg;
        phase_next = phase_reg;
        timer_next = timer_reg + TW'(1);
        pend_next  = pend_reg | REQ;
        if (state_reg == ST_GREEN) pend_next = pend_next & ~phase_onehot;

        case (state_reg)
            ST_ALLRED: begin
                if (timer_reg == TW'(ALLRED_T - 1)) begin
                    state_next = ST_GREEN;
                    phase_next = rr_phase;
                    timer_next = '0;
                end
            end
            ST_GREEN: begin
                if (gap_out || gap_out_ext || max_out) begin
                    state_next = ST_YELLOW;
                    timer_next = '0;
                end else if (timer_reg == TW'(GREEN_MAX - 1)) begin
                    timer_next = timer_reg;
                end
            end
            ST_YELLOW: begin
                if (timer_reg == TW'(YELLOW_T - 1)) begin
                    state_next = ST_ALLRED;
                    timer_next = '0;
                end
            end
            default: begin
                state_next = ST_ALLRED;
                timer_next = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RES) begin
        if (!RES) begin
            state_reg    <= ST_ALLRED;
            phase_reg    <= PW'(N_WAY - 1);
            timer_reg    <= '0;
            pend_reg     <= '0;
            req_prev_reg <= '0;
        end else begin
            state_reg    <= state_next;
            phase_reg    <= phase_next;
            timer_reg    <= timer_next;
            pend_reg     <= pend_next;
            req_prev_reg <= REQ;
        end
    end

    assign GRN   = (state_reg == ST_GREEN)  ? phase_onehot : '0;
    assign YEL   = (state_reg == ST_YELLOW) ? phase_onehot : '0;
    assign RED   = ~(GRN | YEL);
    assign PHASE = phase_reg;
    assign STATE = state_reg;

endmodule
